// File: rtl/shift_reg_sequencer_if.sv
// Command/status and register-side bundle for shift_reg_sequencer.
// Q_fb is the register output; S/SR/SL/PData/reg_clear drive it.
interface shift_reg_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [3:0]       load_data;
  logic [CNT_W-1:0] steps;
  logic             serial_in;
  logic             hold;
  logic [3:0]       Q_fb;
  logic [1:0]       S;
  logic             SR;
  logic             SL;
  logic [3:0]       PData;
  logic             reg_clear;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, mode, load_data, steps,
    output serial_in, hold, Q_fb,
    input  S, SR, SL, PData, reg_clear,
    input  busy, done, remaining
  );

  modport slave (
    input  start, mode, load_data, steps,
    input  serial_in, hold, Q_fb,
    output S, SR, SL, PData, reg_clear,
    output busy, done, remaining
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Sequencer driving a 4-bit universal shift register:
// clear, load, then N shift/rotate steps, with pause.
module shift_reg_sequencer #(
  parameter int CNT_W = 4
) (
  input logic                  clk,
  input logic                  clear,
  shift_reg_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [1:0]       mode_q;
  logic [3:0]       data_q;
  logic [CNT_W-1:0] rem;
  logic             shift_en;

  assign shift_en = (state == SHIFT) && !bus.hold;

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      mode_q <= '0;
      data_q <= '0;
      rem    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            data_q <= bus.load_data;
            rem    <= bus.steps;
            state  <= CLR;
          end
        end
        CLR:  state <= LOAD;
        LOAD: state <= (rem != '0) ? SHIFT : DONE;
        SHIFT: begin
          if (!bus.hold) begin
            rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1))
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // hold gates S directly so a paused cycle never shifts
  always_comb begin
    bus.S         = 2'b00;
    bus.PData     = 4'b0000;
    bus.reg_clear = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state != IDLE);
    unique case (1'b1)
      state == CLR:  bus.reg_clear = 1'b1;
      state == LOAD: begin
        bus.S     = 2'b11;
        bus.PData = data_q;
      end
      shift_en:      bus.S = mode_q[0] ? 2'b10 : 2'b01;
      state == DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bus.SR = 1'b0;
    bus.SL = 1'b0;
    unique case (mode_q)
      2'b00:   bus.SR = bus.serial_in;
      2'b01:   bus.SL = bus.serial_in;
      2'b10:   bus.SR = bus.Q_fb[0];
      default: bus.SL = bus.Q_fb[3];
    endcase
  end

  assign bus.remaining = rem;

endmodule
